// File: rtl/shift_reg_sequencer.sv
// Load/shift/hold sequencer for an external 4-bit universal shift register.
// Optional abort feature enabled by defining SHIFT_SEQ_ABORT_EN.
//
//   state | meaning
//   IDLE  | waiting for start; register held (s=00)
//   LOAD  | parallel load of captured word (s=11)
//   SHIFT | N shift cycles in captured direction (s=01 right, s=10 left)
//   DONE  | hold result, one-cycle done pulse
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    input  logic [CNT_W-1:0] steps,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       sr_s,
    output logic [WIDTH-1:0] sr_d,
    output logic             sr_oe,
    output logic             busy,
`ifdef SHIFT_SEQ_ABORT_EN
    output logic             aborted,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   sr_d_q, sr_d_d;
    logic [1:0]         sr_s_q, sr_s_d;
    logic               sr_oe_q, sr_oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SHIFT_SEQ_ABORT_EN
    logic               aborted_q, aborted_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            sr_d_q    <= '0;
            sr_s_q    <= S_HOLD;
            sr_oe_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            sr_d_q    <= sr_d_d;
            sr_s_q    <= sr_s_d;
            sr_oe_q   <= sr_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SHIFT_SEQ_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // Next state; command parameters are captured only on acceptance in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        sr_d_d  = sr_d_q;
`ifdef SHIFT_SEQ_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    dir_d   = dir;
                    sr_d_d  = load_val;
                    cnt_d   = steps;
                end
            end
            LOAD: begin
                state_d = (cnt_q != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                // Counter is at least 1 here, so the decrement cannot underflow.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef SHIFT_SEQ_ABORT_EN
        if (abort && (state_q == LOAD || state_q == SHIFT)) begin
            state_d   = DONE;
            cnt_d     = '0;
            aborted_d = 1'b1;
        end
`endif
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        sr_s_d  = S_HOLD;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sr_oe_d = sr_oe_q;
        case (state_d)
            IDLE: begin
                sr_s_d = S_HOLD;
            end
            LOAD: begin
                sr_s_d  = S_LOAD;
                busy_d  = 1'b1;
                sr_oe_d = 1'b1;
            end
            SHIFT: begin
                sr_s_d = dir_d ? S_LEFT : S_RIGHT;
                busy_d = 1'b1;
            end
            DONE: begin
                sr_s_d = S_HOLD;
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                sr_s_d = S_HOLD;
            end
        endcase
    end

    assign sr_s    = sr_s_q;
    assign sr_d    = sr_d_q;
    assign sr_oe   = sr_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
`ifdef SHIFT_SEQ_ABORT_EN
    assign aborted = aborted_q;
`endif

endmodule
